// File: rtl/alu_mc.sv
// Multi-cycle RV32I/RV32M ALU with a valid/ready handshake.
// Shared counter paces both the fixed-latency path (MUL state) and the restoring divider (DIV state).
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             dz,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + MUL_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [4:0]       op;
  logic [WIDTH-1:0] opa, opb;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;

  logic                 is_mul_in, is_div_in, signed_in;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [SW-1:0]        shamt;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
  logic [WIDTH-1:0]     alu_res;
  logic                 div_signed, div_zero, div_ovf;
  logic [WIDTH-1:0]     q_fix, r_fix, div_res, special_res;
  logic [WIDTH:0]       shifted, diff;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign is_mul_in = (ctrl >= 5'd10) && (ctrl <= 5'd13);
  assign is_div_in = (ctrl >= 5'd14) && (ctrl <= 5'd17);
  assign signed_in = (ctrl == 5'd14) || (ctrl == 5'd16);
  assign mag_a     = (signed_in && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_in && b[WIDTH-1]) ? -b : b;

  // Operands are extended to 2*WIDTH so one unsigned multiply covers every MUL variant
  assign shamt = opb[SW-1:0];
  assign a_ext = (op == 5'd11 || op == 5'd12) ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
  assign b_ext = (op == 5'd11) ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
  assign prod  = a_ext * b_ext;

  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:  alu_res = opa + opb;
      5'd1:  alu_res = opa - opb;
      5'd2:  alu_res = opa & opb;
      5'd3:  alu_res = opa | opb;
      5'd4:  alu_res = opa ^ opb;
      5'd5:  alu_res = opa << shamt;
      5'd6:  alu_res = opa >> shamt;
      5'd7:  alu_res = $signed(opa) >>> shamt;
      5'd8:  alu_res = {{(WIDTH-1){1'b0}}, $signed(opa) < $signed(opb)};
      5'd9:  alu_res = {{(WIDTH-1){1'b0}}, opa < opb};
      5'd10: alu_res = prod[WIDTH-1:0];
      5'd11, 5'd12, 5'd13: alu_res = prod[2*WIDTH-1:WIDTH];
      default: alu_res = '0;
    endcase
  end

  assign div_signed  = (op == 5'd14) || (op == 5'd16);
  assign div_zero    = (opb == '0);
  assign div_ovf     = div_signed && (opa == {1'b1, {(WIDTH-1){1'b0}}}) && (opb == '1);
  assign special_res = div_zero ? ((op == 5'd14 || op == 5'd15) ? '1 : opa)
                                : ((op == 5'd14) ? opa : '0);

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  // Quotient sign is the XOR of operand signs; remainder follows the dividend
  assign q_fix   = (div_signed && (opa[WIDTH-1] ^ opb[WIDTH-1])) ? -quo : quo;
  assign r_fix   = (div_signed && opa[WIDTH-1]) ? -rem : rem;
  assign div_res = (op == 5'd14 || op == 5'd15) ? q_fix : r_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      opa   <= '0;
      opb   <= '0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      y     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op  <= ctrl;
            opa <= a;
            opb <= b;
            rem <= '0;
            quo <= mag_a;
            dvs <= mag_b;
            if (is_div_in) begin
              state <= DIV;
              cnt   <= '0;
            end else begin
              state <= MUL;
              cnt   <= is_mul_in ? CW'(MUL_LAT) : CW'(1);
            end
          end
        end
        MUL: begin
          if (cnt == CW'(1)) begin
            y     <= alu_res;
            dz    <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (cnt == '0 && (div_zero || div_ovf)) begin
            y     <= special_res;
            dz    <= div_zero;
            state <= DONE;
          end else if (cnt == CW'(WIDTH)) begin
            y     <= div_res;
            dz    <= 1'b0;
            state <= DONE;
          end else begin
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a scoreboard queue holds the expected result, latency and dz per request.
module tb_alu_mc;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready, dz, busy;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] a, b, y;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] y;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_mc #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .dz(dz), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Present one request, record its expectation, then scramble the inputs after acceptance
  task automatic applyStimulus(input string tag, input logic [4:0] c, input logic [31:0] va,
                               input logic [31:0] vb, input logic [31:0] ey, input logic edz,
                               input int elat);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkValue({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    ctrl     = c;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    e.tag = tag; e.y = ey; e.dz = edz; e.lat = elat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl     = 5'($urandom_range(0, 31));
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic checkOutput();
    exp_t e;
    int   n = 0;
    logic busy_ok = 1'b1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard: observed empty queue expected pending entry");
      return;
    end
    e = sb.pop_front();
    while (n < 200) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      n++;
    end
    checkValue({e.tag, " latency"}, 32'(n), 32'(e.lat));
    checkValue({e.tag, " y"}, y, e.y);
    checkValue({e.tag, " dz"}, {31'b0, dz}, {31'b0, e.dz});
    checkValue({e.tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      checkValue({e.tag, " in_ready after accept"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic stable, hold_ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ctrl = '0; a = '0; b = '0;
    #12;
    checkValue("reset y", y, 32'h0);
    checkValue("reset flags", {28'b0, out_valid, busy, in_ready, dz}, 32'b0010);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("add ovf", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1); checkOutput();
    applyStimulus("sra", 5'd7, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1); checkOutput();
    applyStimulus("sub", 5'd1, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1); checkOutput();
    applyStimulus("sll", 5'd5, 32'h1, 32'h3F, 32'h80000000, 1'b0, 1); checkOutput();
    applyStimulus("srl", 5'd6, 32'h80000000, 32'h4, 32'h08000000, 1'b0, 1); checkOutput();
    applyStimulus("slt", 5'd8, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1); checkOutput();
    applyStimulus("sltu", 5'd9, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1); checkOutput();
    applyStimulus("and", 5'd2, 32'hF0F0FF00, 32'h3C3C0FF0, 32'h30300F00, 1'b0, 1); checkOutput();
    applyStimulus("or", 5'd3, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1); checkOutput();
    applyStimulus("ctrl20", 5'd20, 32'h12345678, 32'h9, 32'h0, 1'b0, 1); checkOutput();

    applyStimulus("mulh", 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 2); checkOutput();
    applyStimulus("mulhu", 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 2); checkOutput();
    applyStimulus("mulhsu", 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2); checkOutput();
    applyStimulus("mul", 5'd10, 32'h10000, 32'h10000, 32'h0, 1'b0, 2); checkOutput();
    applyStimulus("mul small", 5'd10, 32'h1234, 32'h10, 32'h12340, 1'b0, 2); checkOutput();

    applyStimulus("div neg", 5'd14, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 33); checkOutput();
    applyStimulus("rem neg", 5'd16, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 33); checkOutput();
    applyStimulus("div negb", 5'd14, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33); checkOutput();
    applyStimulus("rem negb", 5'd16, 32'h7, 32'hFFFFFFFE, 32'h1, 1'b0, 33); checkOutput();
    applyStimulus("divu", 5'd15, 32'd100, 32'd7, 32'd14, 1'b0, 33); checkOutput();
    applyStimulus("remu", 5'd17, 32'd100, 32'd7, 32'd2, 1'b0, 33); checkOutput();
    applyStimulus("divu by0", 5'd15, 32'h5, 32'h0, 32'hFFFFFFFF, 1'b1, 1); checkOutput();
    applyStimulus("remu by0", 5'd17, 32'h7, 32'h0, 32'h7, 1'b1, 1); checkOutput();
    applyStimulus("rem ovf", 5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1); checkOutput();
    applyStimulus("div ovf", 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1); checkOutput();

    // Result must survive ten cycles of backpressure with noisy inputs
    out_ready = 1'b0;
    applyStimulus("xor hold", 5'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0, 1);
    checkOutput();
    stable  = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      a        = $urandom;
      b        = $urandom;
      ctrl     = 5'($urandom_range(0, 31));
      in_valid = ~in_valid;
      @(negedge clk);
      if (y !== 32'hAAAAAAAA) stable = 1'b0;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) hold_ok = 1'b0;
    end
    checkValue("hold y stable", {31'b0, stable}, 32'd1);
    checkValue("hold handshake", {31'b0, hold_ok}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkValue("release in_ready/out_valid", {30'b0, in_ready, out_valid}, 32'b10);
    out_ready = 1'b1;

    // Reset lands in the middle of a divide
    applyStimulus("div reset", 5'd14, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    repeat (10) @(posedge clk);
    #2;
    checkValue("busy before reset", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkValue("mid-div reset y", y, 32'h0);
    checkValue("mid-div reset flags", {28'b0, out_valid, busy, in_ready, dz}, 32'b0010);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("add after reset", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1); checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
